// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg
// Shared definitions for the SAP-style CPU control path: bit positions inside
// the 15-bit control word, the idle control word, opcode values, the T-state
// enumeration and small decode helpers used by the sequencer and the ROM.
package cpu_ctrl_pkg;

    localparam int CTRL_W = 15;

    // Control word layout, MSB first:
    // {cp, ep, lp, n_lma, n_lmd, n_ce, n_lr, n_li, n_ei, n_la, ea, sub, eu, n_lb, n_lo}
    localparam int B_CP    = 14;
    localparam int B_EP    = 13;
    localparam int B_LP    = 12;
    localparam int B_N_LMA = 11;
    localparam int B_N_LMD = 10;
    localparam int B_N_CE  = 9;
    localparam int B_N_LR  = 8;
    localparam int B_N_LI  = 7;
    localparam int B_N_EI  = 6;
    localparam int B_N_LA  = 5;
    localparam int B_EA    = 4;
    localparam int B_SUB   = 3;
    localparam int B_EU    = 2;
    localparam int B_N_LB  = 1;
    localparam int B_N_LO  = 0;

    // Every active-high strobe low, every active-low strobe high.
    localparam logic [CTRL_W-1:0] CTRL_IDLE = 15'b000_1111_11_1000_11;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4,
        T5 = 3'd5,
        T6 = 3'd6,
        T7 = 3'd7
    } t_state_e;

    // Opcodes beyond the 4-bit table (only possible when OPCODE_W > 4)
    // collapse to NOP so they can never alias a real instruction.
    function automatic logic [3:0] norm_opcode(input logic [31:0] op);
        return (op < 32'd16) ? op[3:0] : OP_NOP;
    endfunction

    // Final micro-step of each instruction; the step after it is T0.
    function automatic t_state_e last_step(input logic [3:0] op);
        case (op)
            OP_LDA:                 return T4;
            OP_ADD, OP_SUB, OP_STA: return T5;
            default:                return T3;
        endcase
    endfunction

endpackage

// File: rtl/microcode_rom.sv
// microcode_rom
// Purely combinational decode of (micro-step, opcode, flags) into the control
// word. Holds no state; halt/pause masking happens in the sequencer.
// Ports:
//   t_state  in  T_W       current micro-step
//   opcode   in  OPCODE_W  IR opcode (meaningful from T3)
//   cf, zf   in  1         ALU flags, consulted at T3 by JC/JZ only
//   ctrl     out 15        control word
module microcode_rom
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int T_W      = 3
) (
    input  logic [T_W-1:0]      t_state,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                cf,
    input  logic                zf,
    output logic [CTRL_W-1:0]   ctrl
);

    logic [3:0] op;
    t_state_e   ts;

    assign op = norm_opcode(32'(opcode));
    assign ts = t_state_e'(3'(t_state));

    always_comb begin
        ctrl = CTRL_IDLE;
        case (ts)
            T0: begin
                ctrl[B_EP]    = 1'b1;
                ctrl[B_N_LMA] = 1'b0;
            end
            T1: begin
                ctrl[B_CP] = 1'b1;
            end
            T2: begin
                ctrl[B_N_CE] = 1'b0;
                ctrl[B_N_LI] = 1'b0;
            end
            T3: begin
                case (op)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        ctrl[B_N_EI]  = 1'b0;
                        ctrl[B_N_LMA] = 1'b0;
                    end
                    OP_LDI: begin
                        ctrl[B_N_EI] = 1'b0;
                        ctrl[B_N_LA] = 1'b0;
                    end
                    OP_JMP: begin
                        ctrl[B_N_EI] = 1'b0;
                        ctrl[B_LP]   = 1'b1;
                    end
                    OP_JC: begin
                        if (cf) begin
                            ctrl[B_N_EI] = 1'b0;
                            ctrl[B_LP]   = 1'b1;
                        end
                    end
                    OP_JZ: begin
                        if (zf) begin
                            ctrl[B_N_EI] = 1'b0;
                            ctrl[B_LP]   = 1'b1;
                        end
                    end
                    OP_OUT: begin
                        ctrl[B_EA]   = 1'b1;
                        ctrl[B_N_LO] = 1'b0;
                    end
                    default: ;
                endcase
            end
            T4: begin
                case (op)
                    OP_LDA: begin
                        ctrl[B_N_CE] = 1'b0;
                        ctrl[B_N_LA] = 1'b0;
                    end
                    OP_ADD, OP_SUB: begin
                        ctrl[B_N_CE] = 1'b0;
                        ctrl[B_N_LB] = 1'b0;
                    end
                    OP_STA: begin
                        ctrl[B_EA]    = 1'b1;
                        ctrl[B_N_LMD] = 1'b0;
                    end
                    default: ;
                endcase
            end
            T5: begin
                case (op)
                    OP_ADD: begin
                        ctrl[B_EU]   = 1'b1;
                        ctrl[B_N_LA] = 1'b0;
                    end
                    OP_SUB: begin
                        ctrl[B_EU]   = 1'b1;
                        ctrl[B_SUB]  = 1'b1;
                        ctrl[B_N_LA] = 1'b0;
                    end
                    OP_STA: begin
                        ctrl[B_N_LR] = 1'b0;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/microcode_sequencer.sv
// microcode_sequencer
// T-state sequencer for the SAP-style CPU: steps through fetch and execute
// micro-steps, returns to T0 early for short instructions, latches HLT and
// implements run / single-step control at instruction boundaries.
// Ports:
//   clk      in  1         system clock, rising edge
//   rst      in  1         asynchronous active-high reset
//   opcode   in  OPCODE_W  IR opcode (valid from T3)
//   cf, zf   in  1         ALU flags
//   run      in  1         1 = free-run, 0 = pause at instruction boundary
//   step     in  1         rising edge releases one instruction while paused
//   ctrl     out 15        control word to all bus agents
//   t_state  out T_W       current micro-step
//   halted   out 1         HLT executed
//   paused   out 1         held at T0 by run=0
//
// state | meaning
// T0    | fetch: PC onto bus, load MAR (idle while paused or halted)
// T1    | fetch: increment PC
// T2    | fetch: RAM onto bus, load IR
// T3    | execute step 1; last step for NOP/LDI/JMP/Jcc/OUT/HLT
// T4    | execute step 2; last step for LDA
// T5    | execute step 3; last step for ADD/SUB/STA
// T6-T7 | headroom only when T_MAX > 6, never reached by current opcodes
module microcode_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int T_MAX    = 6,   // legal range 6..8
    parameter int T_W      = $clog2(T_MAX)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                cf,
    input  logic                zf,
    input  logic                run,
    input  logic                step,
    output logic [CTRL_W-1:0]   ctrl,
    output logic [T_W-1:0]      t_state,
    output logic                halted,
    output logic                paused
);

    localparam t_state_e T_LAST = t_state_e'(3'(T_MAX - 1));

    t_state_e          state;
    logic              step_q;
    logic              step_rise;
    logic              release_req;
    logic [3:0]        op;
    logic [CTRL_W-1:0] rom_ctrl;

    assign op          = norm_opcode(32'(opcode));
    assign step_rise   = step & ~step_q;
    assign release_req = run | step_rise;
    assign t_state     = T_W'(state);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= T0;
            halted <= 1'b0;
            paused <= 1'b0;
            step_q <= 1'b0;
        end else begin
            // The edge detector runs every cycle, so a step seen mid-instruction
            // is consumed rather than remembered for the next boundary.
            step_q <= step;
            if (halted) begin
                state <= T0;
            end else if (paused) begin
                // Leave pause but stay in T0 for one cycle so the fetch
                // strobes of T0 are actually driven before moving to T1.
                if (release_req) begin
                    paused <= 1'b0;
                end
            end else if (state == T3 && op == OP_HLT) begin
                halted <= 1'b1;
                state  <= T0;
            end else if (state == last_step(op) || state == T_LAST) begin
                state  <= T0;
                paused <= ~release_req;
            end else begin
                state <= t_state_e'(3'(state) + 3'd1);
            end
        end
    end

    microcode_rom #(
        .OPCODE_W (OPCODE_W),
        .T_W      (T_W)
    ) u_rom (
        .t_state (t_state),
        .opcode  (opcode),
        .cf      (cf),
        .zf      (zf),
        .ctrl    (rom_ctrl)
    );

    // Reset is included so the bus sees no strobes while rst is asserted.
    assign ctrl = (rst || halted || paused) ? CTRL_IDLE : rom_ctrl;

endmodule

// File: tb/tb_microcode_sequencer.sv
module tb_microcode_sequencer;

    localparam logic [14:0] C_IDLE  = 15'h0FE3;
    localparam logic [14:0] C_T0    = 15'h27E3;
    localparam logic [14:0] C_T1    = 15'h4FE3;
    localparam logic [14:0] C_T2    = 15'h0D63;
    localparam logic [14:0] C_ADDR  = 15'h07A3;  // n_ei=0, n_lma=0
    localparam logic [14:0] C_LDA4  = 15'h0DC3;  // n_ce=0, n_la=0
    localparam logic [14:0] C_ADD4  = 15'h0DE1;  // n_ce=0, n_lb=0
    localparam logic [14:0] C_ADD5  = 15'h0FC7;  // eu, n_la=0
    localparam logic [14:0] C_SUB5  = 15'h0FCF;  // eu, sub, n_la=0
    localparam logic [14:0] C_STA4  = 15'h0BF3;  // ea, n_lmd=0
    localparam logic [14:0] C_STA5  = 15'h0EE3;  // n_lr=0
    localparam logic [14:0] C_LDI3  = 15'h0F83;  // n_ei=0, n_la=0
    localparam logic [14:0] C_JMP3  = 15'h1FA3;  // n_ei=0, lp
    localparam logic [14:0] C_OUT3  = 15'h0FF2;  // ea, n_lo=0

    logic        clk;
    logic        rst;
    logic [3:0]  opcode;
    logic        cf;
    logic        zf;
    logic        run;
    logic        step;
    logic [14:0] ctrl;
    logic [2:0]  t_state;
    logic        halted;
    logic        paused;

    int passed;
    int total;

    microcode_sequencer #(
        .OPCODE_W (4),
        .T_MAX    (6)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .opcode  (opcode),
        .cf      (cf),
        .zf      (zf),
        .run     (run),
        .step    (step),
        .ctrl    (ctrl),
        .t_state (t_state),
        .halted  (halted),
        .paused  (paused)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        total++; if (t_state !== 3'd0) $display("FAIL reset_t got %0d exp 0", t_state); else passed++;
        total++; if (halted !== 1'b0) $display("FAIL reset_halted got %b exp 0", halted); else passed++;
        total++; if (paused !== 1'b0) $display("FAIL reset_paused got %b exp 0", paused); else passed++;
        total++; if (ctrl !== C_IDLE) $display("FAIL reset_ctrl got %h exp %h", ctrl, C_IDLE); else passed++;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        total++; if (ctrl !== C_T0) $display("FAIL reset_first_fetch got %h exp %h", ctrl, C_T0); else passed++;
    endtask

    task automatic test_lda();
        logic [2:0]  et [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        logic [14:0] ec [6] = '{C_T0, C_T1, C_T2, C_ADDR, C_LDA4, C_T0};
        opcode = 4'h1; run = 1'b1;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            total++; if (t_state !== et[i]) $display("FAIL lda_t[%0d] got %0d exp %0d", i, t_state, et[i]); else passed++;
            total++; if (ctrl !== ec[i]) $display("FAIL lda_ctrl[%0d] got %h exp %h", i, ctrl, ec[i]); else passed++;
            cyc();
        end
    endtask

    task automatic test_add_sub(input logic [3:0] op, input logic [14:0] t5);
        logic [2:0]  et [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
        logic [14:0] ec [7] = '{C_T0, C_T1, C_T2, C_ADDR, C_ADD4, t5, C_T0};
        opcode = op; run = 1'b1;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            total++; if (t_state !== et[i]) $display("FAIL alu%0h_t[%0d] got %0d exp %0d", op, i, t_state, et[i]); else passed++;
            total++; if (ctrl !== ec[i]) $display("FAIL alu%0h_ctrl[%0d] got %h exp %h", op, i, ctrl, ec[i]); else passed++;
            cyc();
        end
    endtask

    task automatic test_sta();
        logic [2:0]  et [4] = '{3'd3, 3'd4, 3'd5, 3'd0};
        logic [14:0] ec [4] = '{C_ADDR, C_STA4, C_STA5, C_T0};
        opcode = 4'h4; run = 1'b1;
        do_reset();
        repeat (3) cyc();
        for (int i = 0; i < 4; i++) begin
            total++; if (t_state !== et[i]) $display("FAIL sta_t[%0d] got %0d exp %0d", i, t_state, et[i]); else passed++;
            total++; if (ctrl !== ec[i]) $display("FAIL sta_ctrl[%0d] got %h exp %h", i, ctrl, ec[i]); else passed++;
            cyc();
        end
    endtask

    task automatic test_jcc();
        logic [3:0]  ops [4] = '{4'h7, 4'h7, 4'h8, 4'h8};
        logic        fl  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [14:0] ec  [4] = '{C_JMP3, C_IDLE, C_JMP3, C_IDLE};
        run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            opcode = ops[i];
            cf = (ops[i] == 4'h7) ? fl[i] : ~fl[i];
            zf = (ops[i] == 4'h8) ? fl[i] : ~fl[i];
            do_reset();
            repeat (3) cyc();
            total++; if (t_state !== 3'd3) $display("FAIL jcc%0d_t3 got %0d exp 3", i, t_state); else passed++;
            total++; if (ctrl !== ec[i]) $display("FAIL jcc%0d_ctrl got %h exp %h", i, ctrl, ec[i]); else passed++;
            cyc();
            total++; if (t_state !== 3'd0) $display("FAIL jcc%0d_ret got %0d exp 0", i, t_state); else passed++;
        end
        cf = 1'b0; zf = 1'b0;
    endtask

    task automatic test_short_ops();
        logic [3:0]  ops [6] = '{4'h5, 4'h6, 4'hE, 4'h0, 4'hA, 4'hC};
        logic [14:0] ec  [6] = '{C_LDI3, C_JMP3, C_OUT3, C_IDLE, C_IDLE, C_IDLE};
        run = 1'b1;
        for (int i = 0; i < 6; i++) begin
            opcode = ops[i];
            do_reset();
            repeat (3) cyc();
            total++; if (ctrl !== ec[i]) $display("FAIL op%0h_t3_ctrl got %h exp %h", ops[i], ctrl, ec[i]); else passed++;
            cyc();
            total++; if (t_state !== 3'd0) $display("FAIL op%0h_ret got %0d exp 0", ops[i], t_state); else passed++;
            total++; if (ctrl !== C_T0) $display("FAIL op%0h_refetch got %h exp %h", ops[i], ctrl, C_T0); else passed++;
        end
    endtask

    task automatic test_reset_mid();
        opcode = 4'h2; run = 1'b1;
        do_reset();
        repeat (4) cyc();
        total++; if (t_state !== 3'd4) $display("FAIL rmid_pre_t got %0d exp 4", t_state); else passed++;
        total++; if (ctrl !== C_ADD4) $display("FAIL rmid_pre_ctrl got %h exp %h", ctrl, C_ADD4); else passed++;
        rst = 1'b1;
        #1;
        total++; if (t_state !== 3'd0) $display("FAIL rmid_t got %0d exp 0", t_state); else passed++;
        total++; if (ctrl !== C_IDLE) $display("FAIL rmid_ctrl got %h exp %h", ctrl, C_IDLE); else passed++;
        total++; if (halted !== 1'b0) $display("FAIL rmid_halted got %b exp 0", halted); else passed++;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        total++; if (ctrl !== C_T0) $display("FAIL rmid_fetch got %h exp %h", ctrl, C_T0); else passed++;
        cyc();
        total++; if (t_state !== 3'd1) $display("FAIL rmid_t1 got %0d exp 1", t_state); else passed++;
    endtask

    task automatic test_hlt();
        opcode = 4'hF; run = 1'b1; step = 1'b0;
        do_reset();
        repeat (3) cyc();
        total++; if (t_state !== 3'd3) $display("FAIL hlt_t3 got %0d exp 3", t_state); else passed++;
        total++; if (halted !== 1'b0) $display("FAIL hlt_early got %b exp 0", halted); else passed++;
        total++; if (ctrl !== C_IDLE) $display("FAIL hlt_t3_ctrl got %h exp %h", ctrl, C_IDLE); else passed++;
        cyc();
        total++; if (halted !== 1'b1) $display("FAIL hlt_set got %b exp 1", halted); else passed++;
        for (int i = 0; i < 20; i++) begin
            step = ~step;
            cyc();
            total++; if (t_state !== 3'd0) $display("FAIL hlt_hold_t[%0d] got %0d exp 0", i, t_state); else passed++;
            total++; if (ctrl !== C_IDLE) $display("FAIL hlt_hold_ctrl[%0d] got %h exp %h", i, ctrl, C_IDLE); else passed++;
        end
        total++; if (halted !== 1'b1) $display("FAIL hlt_sticky got %b exp 1", halted); else passed++;
        step = 1'b0;
    endtask

    task automatic test_pause();
        opcode = 4'h0; run = 1'b0; step = 1'b0;
        do_reset();
        repeat (4) cyc();
        total++; if (paused !== 1'b1) $display("FAIL pause_enter got %b exp 1", paused); else passed++;
        total++; if (t_state !== 3'd0) $display("FAIL pause_t got %0d exp 0", t_state); else passed++;
        total++; if (ctrl !== C_IDLE) $display("FAIL pause_ctrl got %h exp %h", ctrl, C_IDLE); else passed++;
        repeat (3) cyc();
        total++; if (paused !== 1'b1 || t_state !== 3'd0) $display("FAIL pause_hold got p=%b t=%0d exp p=1 t=0", paused, t_state); else passed++;
        step = 1'b1;
        cyc();
        total++; if (paused !== 1'b0) $display("FAIL step_release got %b exp 0", paused); else passed++;
        total++; if (ctrl !== C_T0) $display("FAIL step_fetch got %h exp %h", ctrl, C_T0); else passed++;
        for (int i = 1; i < 4; i++) begin
            cyc();
            total++; if (t_state !== 3'(i)) $display("FAIL step_t[%0d] got %0d exp %0d", i, t_state, i); else passed++;
        end
        cyc();
        total++; if (paused !== 1'b1) $display("FAIL step_repause got %b exp 1", paused); else passed++;
        for (int i = 0; i < 6; i++) begin
            cyc();
            total++; if (paused !== 1'b1 || t_state !== 3'd0) $display("FAIL step_held[%0d] got p=%b t=%0d exp p=1 t=0", i, paused, t_state); else passed++;
        end
        step = 1'b0;
        cyc();
        run = 1'b1;
        cyc();
        total++; if (paused !== 1'b0) $display("FAIL run_release got %b exp 0", paused); else passed++;
        total++; if (ctrl !== C_T0) $display("FAIL run_fetch got %h exp %h", ctrl, C_T0); else passed++;
        cyc();
        total++; if (t_state !== 3'd1) $display("FAIL run_t1 got %0d exp 1", t_state); else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        opcode = 4'h0;
        cf     = 1'b0;
        zf     = 1'b0;
        run    = 1'b1;
        step   = 1'b0;
        test_reset();
        test_lda();
        test_add_sub(4'h2, C_ADD5);
        test_add_sub(4'h3, C_SUB5);
        test_sta();
        test_jcc();
        test_short_ops();
        test_reset_mid();
        test_hlt();
        test_pause();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
